// File: rtl/sim_uart_pkg.sv
// Shared register map for the simulation UART. The firmware header mirrors
// these offsets and bit positions, so keep both in step.
package sim_uart_pkg;

    // Byte offsets inside the 16-byte UART window
    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_CTRL   = 4'h8;

    // STATUS bit positions
    localparam int ST_RX_FULL     = 0;
    localparam int ST_TX_READY    = 1;
    localparam int ST_RX_OVERRUN  = 2;
    localparam int ST_IRQ_PENDING = 3;

    // CTRL bit positions
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // Register selected by word index bus_addr[3:2]
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } uart_reg_e;

    function automatic uart_reg_e reg_sel(input logic [1:0] word_idx);
        return uart_reg_e'(word_idx);
    endfunction

    // Packs the STATUS read word; unused upper bits read as zero
    function automatic logic [31:0] status_word(input logic rx_full,
                                                input logic tx_ready,
                                                input logic rx_overrun,
                                                input logic irq_pending);
        logic [31:0] w;
        w                 = 32'h0;
        w[ST_RX_FULL]     = rx_full;
        w[ST_TX_READY]    = tx_ready;
        w[ST_RX_OVERRUN]  = rx_overrun;
        w[ST_IRQ_PENDING] = irq_pending;
        return w;
    endfunction

endpackage

// File: rtl/sim_uart_if.sv
// System-bus slave interface for the simulation UART window.
interface sim_uart_if;
    logic        cs;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_val;
    logic [3:0]  bus_bytesel;
    logic        bus_ack;
    logic [31:0] bus_data;

    modport master (
        output cs, bus_addr, bus_wr_val, bus_bytesel,
        input  bus_ack, bus_data
    );

    modport slave (
        input  cs, bus_addr, bus_wr_val, bus_bytesel,
        output bus_ack, bus_data
    );
endinterface

// File: rtl/sim_uart.sv
// Simulation UART: TX sink that prints to the console, one-byte RX holding
// register fed from injection ports, and a level interrupt with edge ack.
module sim_uart
    import sim_uart_pkg::*;
#(
    parameter bit SIM_PRINT       = 1'b1,
    parameter bit TX_READY_ALWAYS = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    sim_uart_if.slave   bus,
    output logic        inter,
    input  logic        intack,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid
);

    logic [7:0] rx_buf;
    logic       rx_full;
    logic       rx_overrun;
    logic       irq_pending;
    logic       rx_irq_en;
    logic       tx_irq_en;
    logic       intack_q;

    uart_reg_e  reg_idx;
    logic       wr;
    logic       wr_data;
    logic       wr_status;
    logic       wr_ctrl;
    logic       pop;
    logic       rx_full_after_pop;
    logic       rx_load;
    logic       rx_drop;
    logic       irq_set;
    logic       irq_clr;
    logic       unused_bits;

    // Only addr[3:2], wr_val[7:0] and bytesel[0] carry meaning here
    assign unused_bits = ^{bus.bus_addr[31:4], bus.bus_addr[1:0],
                           bus.bus_wr_val[31:8], bus.bus_bytesel[3:1]};

    assign reg_idx   = reg_sel(bus.bus_addr[3:2]);
    assign wr        = bus.cs && bus.bus_bytesel[0];
    assign wr_data   = wr && (reg_idx == REG_DATA);
    assign wr_status = wr && (reg_idx == REG_STATUS);
    assign wr_ctrl   = wr && (reg_idx == REG_CTRL);

    // A pop in the same cycle as an injected byte frees the slot first,
    // so the new byte is accepted rather than counted as an overrun.
    assign pop               = wr_status && bus.bus_wr_val[ST_RX_FULL];
    assign rx_full_after_pop = rx_full && !pop;
    assign rx_load           = rx_valid && !rx_full_after_pop;
    assign rx_drop           = rx_valid && rx_full_after_pop;

    assign irq_set = (rx_load && rx_irq_en) || (wr_data && tx_irq_en);
    assign irq_clr = (intack && !intack_q)
                   || (wr_status && bus.bus_wr_val[ST_IRQ_PENDING]);

    assign inter = irq_pending;

    // Read mux: purely combinational on addr so data is valid in the first cs cycle
    always_comb begin
        bus.bus_data = 32'h0;
        case (reg_idx)
            REG_DATA:   bus.bus_data = {24'h0, rx_buf};
            REG_STATUS: bus.bus_data = status_word(rx_full, TX_READY_ALWAYS,
                                                   rx_overrun, irq_pending);
            REG_CTRL:   bus.bus_data = {30'h0, tx_irq_en, rx_irq_en};
            default:    bus.bus_data = 32'h0;
        endcase
    end

    // Bus acknowledge and TX sink; the console print happens on the write edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.bus_ack <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h0;
        end else begin
            bus.bus_ack <= bus.cs;
            tx_valid    <= wr_data;
            if (wr_data) begin
                tx_data <= bus.bus_wr_val[7:0];
                if (SIM_PRINT) begin
                    $write("%c", bus.bus_wr_val[7:0]);
                end
            end
        end
    end

    // RX holding register, full flag and sticky overrun
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_buf     <= 8'h0;
            rx_full    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_buf <= rx_data;
            end
            rx_full <= rx_load || rx_full_after_pop;
            if (rx_drop) begin
                rx_overrun <= 1'b1;
            end else if (wr_status && bus.bus_wr_val[ST_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    // Control register, ack edge detector and pending interrupt (set beats clear)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
            intack_q    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_irq_en <= bus.bus_wr_val[CTRL_RX_IRQ_EN];
                tx_irq_en <= bus.bus_wr_val[CTRL_TX_IRQ_EN];
            end
            intack_q <= intack;
            if (irq_set) begin
                irq_pending <= 1'b1;
            end else if (irq_clr) begin
                irq_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sim_uart.sv
// Directed and randomized bench for sim_uart with a queue-based reference model.
module tb_sim_uart;
    import sim_uart_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       inter;
    logic       intack = 1'b0;
    logic [7:0] rx_data = 8'h0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks = 0;
    int errors = 0;

    sim_uart_if bus ();

    sim_uart #(.SIM_PRINT(1'b1), .TX_READY_ALWAYS(1'b1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .inter    (inter),
        .intack   (intack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // Reference model: the RX slot is a queue holding at most one byte
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    logic       m_ovr;
    logic       m_irq;
    logic [1:0] m_ctrl;
    logic       m_ack_prev;
    logic [7:0] m_txd;
    logic       m_txv;

    task automatic m_reset();
        m_q.delete();
        m_last = 8'h0; m_ovr = 1'b0; m_irq = 1'b0; m_ctrl = 2'b00;
        m_ack_prev = 1'b0; m_txd = 8'h0; m_txv = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] off);
        logic [31:0] r;
        r = 32'h0;
        if (off == UART_DATA)   r = {24'h0, m_last};
        if (off == UART_STATUS) r = {28'h0, m_irq, m_ovr, 1'b1, (m_q.size() != 0)};
        if (off == UART_CTRL)   r = {30'h0, m_ctrl};
        return r;
    endfunction

    task automatic m_step(input logic wr, input logic [3:0] off, input logic [31:0] val,
                          input logic rxv, input logic [7:0] rxd, input logic ack);
        logic loaded, dropped, clr, st;
        loaded = 1'b0; dropped = 1'b0;
        st = wr && (off == UART_STATUS);
        if (st && val[0] && m_q.size() != 0) void'(m_q.pop_front());
        if (rxv) begin
            if (m_q.size() == 0) begin
                m_q.push_back(rxd); m_last = rxd; loaded = 1'b1;
            end else begin
                dropped = 1'b1;
            end
        end
        if (st && val[2]) m_ovr = 1'b0;
        if (dropped) m_ovr = 1'b1;
        clr = (ack && !m_ack_prev) || (st && val[3]);
        if (clr) m_irq = 1'b0;
        if ((loaded && m_ctrl[0]) || (wr && off == UART_DATA && m_ctrl[1])) m_irq = 1'b1;
        m_txv = wr && (off == UART_DATA);
        if (m_txv) m_txd = val[7:0];
        if (wr && off == UART_CTRL) m_ctrl = val[1:0];
        m_ack_prev = ack;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model advances with the same inputs
    task automatic step(input logic cs, input logic [3:0] off, input logic [31:0] val,
                        input logic [3:0] bsel, input logic rxv, input logic [7:0] rxd,
                        input logic ack);
        bus.cs = cs;
        bus.bus_addr = {28'h1000000, off};
        bus.bus_wr_val = val;
        bus.bus_bytesel = cs ? bsel : 4'h0;
        rx_valid = rxv;
        rx_data = rxd;
        intack = ack;
        m_step(cs && bsel[0], off, val, rxv, rxd, ack);
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        bus.bus_bytesel = 4'h0;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b0, 8'h0, intack);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        bus.bus_addr = {28'h1000000, off};
        #1;
        d = bus.bus_data;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        chk(tag, d, exp);
    endtask

    task automatic check_model(input string tag);
        chk_reg({tag, ".data"},   UART_DATA,   m_read(UART_DATA));
        chk_reg({tag, ".status"}, UART_STATUS, m_read(UART_STATUS));
        chk_reg({tag, ".ctrl"},   UART_CTRL,   m_read(UART_CTRL));
        chk({tag, ".inter"},    32'(inter),    32'(m_irq));
        chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(m_txv));
        chk({tag, ".tx_data"},  32'(tx_data),  32'(m_txd));
    endtask

    initial begin
        logic [31:0] val;
        logic [3:0]  off;
        logic        wr;
        logic        rxv;
        logic        ack;

        bus.cs = 1'b0;
        bus.bus_addr = 32'h1000_0000;
        bus.bus_wr_val = 32'h0;
        bus.bus_bytesel = 4'h0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.inter", 32'(inter), 32'h0);
        chk("rst.bus_ack", 32'(bus.bus_ack), 32'h0);
        chk("rst.tx_valid", 32'(tx_valid), 32'h0);
        chk_reg("rst.status", UART_STATUS, 32'h2);
        chk_reg("rst.ctrl", UART_CTRL, 32'h0);
        chk_reg("rst.data", UART_DATA, 32'h0);
        resetn = 1'b1;
        idle(1);

        // TX: one pulse per honoured write, bytesel[0]=0 ignored
        step(1'b1, UART_DATA, 32'h41, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk("tx.valid", 32'(tx_valid), 32'h1);
        chk("tx.data", 32'(tx_data), 32'h41);
        chk("tx.ack", 32'(bus.bus_ack), 32'h1);
        idle(1);
        chk("tx.valid_drop", 32'(tx_valid), 32'h0);
        chk("tx.ack_drop", 32'(bus.bus_ack), 32'h0);
        step(1'b1, UART_DATA, 32'h42, 4'b0010, 1'b0, 8'h0, 1'b0);
        chk("tx.nosel_valid", 32'(tx_valid), 32'h0);
        chk("tx.nosel_data", 32'(tx_data), 32'h41);

        // RX load and pop
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b1, 8'h5A, 1'b0);
        chk_reg("rx.status", UART_STATUS, 32'h3);
        chk_reg("rx.data1", UART_DATA, 32'h5A);
        chk_reg("rx.data2", UART_DATA, 32'h5A);
        step(1'b1, UART_STATUS, 32'h1, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk_reg("rx.pop", UART_STATUS, 32'h2);

        // Overrun, then pop and load in the same cycle
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b1, 8'h11, 1'b0);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b1, 8'h22, 1'b0);
        chk_reg("ovr.data", UART_DATA, 32'h11);
        chk_reg("ovr.status", UART_STATUS, 32'h7);
        step(1'b1, UART_STATUS, 32'h4, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk_reg("ovr.clear", UART_STATUS, 32'h3);
        step(1'b1, UART_STATUS, 32'h1, 4'b0001, 1'b1, 8'h33, 1'b0);
        chk_reg("simul.data", UART_DATA, 32'h33);
        chk_reg("simul.status", UART_STATUS, 32'h3);
        step(1'b1, UART_STATUS, 32'h1, 4'b0001, 1'b0, 8'h0, 1'b0);

        // Interrupt from RX, cleared by intack rising edge
        step(1'b1, UART_CTRL, 32'h1, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk_reg("irq.ctrl", UART_CTRL, 32'h1);
        chk("irq.idle", 32'(inter), 32'h0);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b1, 8'h05, 1'b0);
        chk("irq.set", 32'(inter), 32'h1);
        chk_reg("irq.status", UART_STATUS, 32'hB);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b0, 8'h0, 1'b1);
        chk("irq.ack", 32'(inter), 32'h0);
        step(1'b1, UART_STATUS, 32'h1, 4'b0001, 1'b0, 8'h0, 1'b1);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b1, 8'h66, 1'b1);
        chk("irq.reassert", 32'(inter), 32'h1);
        idle(3);
        chk("irq.held_ack", 32'(inter), 32'h1);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b0, 8'h0, 1'b0);
        chk("irq.ack_low", 32'(inter), 32'h1);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b0, 8'h0, 1'b1);
        chk("irq.ack_edge", 32'(inter), 32'h0);
        chk_reg("irq.status2", UART_STATUS, 32'h3);

        // TX interrupt, STATUS clear, and set beating clear
        step(1'b1, UART_CTRL, 32'h3, 4'b0001, 1'b0, 8'h0, 1'b0);
        step(1'b1, UART_DATA, 32'h37, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk("txirq.inter", 32'(inter), 32'h1);
        chk("txirq.valid", 32'(tx_valid), 32'h1);
        step(1'b1, UART_STATUS, 32'h8, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk("stclr.inter", 32'(inter), 32'h0);
        chk_reg("stclr.status", UART_STATUS, 32'h3);
        step(1'b1, UART_STATUS, 32'h9, 4'b0001, 1'b1, 8'h77, 1'b0);
        chk("setwin.inter", 32'(inter), 32'h1);
        chk_reg("setwin.data", UART_DATA, 32'h77);
        chk_reg("setwin.status", UART_STATUS, 32'hB);
        step(1'b1, UART_STATUS, 32'hD, 4'b0001, 1'b0, 8'h0, 1'b0);
        chk_reg("tidy.status", UART_STATUS, 32'h2);
        check_model("directed_end");

        // Asynchronous reset between clock edges
        step(1'b1, UART_CTRL, 32'h1, 4'b0001, 1'b0, 8'h0, 1'b0);
        step(1'b0, UART_DATA, 32'h0, 4'h0, 1'b1, 8'h99, 1'b0);
        chk("arst.pre_inter", 32'(inter), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.inter", 32'(inter), 32'h0);
        chk_reg("arst.status", UART_STATUS, 32'h2);
        chk_reg("arst.ctrl", UART_CTRL, 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            wr  = ($urandom_range(0, 2) == 0);
            off = {2'($urandom_range(0, 3)), 2'b00};
            if (off == UART_DATA)
                val = ($urandom() & 32'hFFFF_FF00) | (32'h30 + 32'($urandom_range(0, 9)));
            else
                val = $urandom();
            rxv = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 3) == 0) ? !intack : intack;
            step(wr, off, val, 4'($urandom_range(0, 15)), rxv, 8'($urandom()), ack);
            check_model("rand");
        end

        $display("");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_uart.md
Name: sim_uart

Overview:
- Memory-mapped, simulation-oriented UART peripheral for the picorv32 system bus.
- Occupies a 16-byte window that the system decodes externally (base 0x1000_0000, cs = addr[31:4]==0x1000000 && mem_valid).
- Provides a TX data sink that prints characters in simulation, a single-byte RX holding register fed from injection ports, and a level interrupt with an acknowledge input (irq line 0 / eoi line 0).

Parameters:
- SIM_PRINT, 1, when 1 each TX byte is printed to the simulator console with %c; 0 disables printing.
- TX_READY_ALWAYS, 1, STATUS.tx_ready constant 1; TX never back-pressures.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- cs  in  1  chip select, high while the CPU addresses the UART window.
- bus_addr  in  32  byte address; only [3:2] decoded.
- bus_wr_val  in  32  write data; only [7:0] used.
- bus_bytesel  in  4  write byte strobes; already gated by the system so they are nonzero for exactly one cycle per write.
- bus_ack  out  1  registered acknowledge.
- bus_data  out  32  read data, combinational.
- inter  out  1  interrupt request, level.
- intack  in  1  interrupt acknowledge (eoi).
- rx_data  in  8  injected receive byte; tie to 0 if unused.
- rx_valid  in  1  one-cycle strobe loading rx_data; tie to 0 if unused.
- tx_data  out  8  last transmitted byte.
- tx_valid  out  1  one-cycle pulse per transmitted byte.

Behaviour:
- Write = cs && bus_bytesel[0]; honoured in that single cycle. Writes with bytesel[0]=0 are ignored.
- Register map, offset by bus_addr[3:2]:
  - 0x0 DATA. Write: tx_data<=wr[7:0], tx_valid pulses 1 next cycle; if SIM_PRINT, $write the byte in that cycle. Read: {24'b0, rx_buf}.
  - 0x4 STATUS. Read: bit0 rx_full, bit1 tx_ready(=1), bit2 rx_overrun, bit3 irq_pending, others 0. Write: bit0=1 clears rx_full (pop); bit2=1 clears rx_overrun; bit3=1 clears irq_pending.
  - 0x8 CTRL. R/W bit0 rx_irq_en, bit1 tx_irq_en; other bits read 0.
  - 0xC reads 0; writes ignored.
- Reads have no side effects. bus_data is a combinational mux of registers by bus_addr[3:2], independent of cs, so it is valid in the first cs cycle and stable on repeat sampling.
- bus_ack: registered, equals cs delayed one cycle.
- RX path:
  - rx_valid with rx_full=0: rx_buf<=rx_data, rx_full<=1.
  - rx_valid with rx_full=1: byte dropped, rx_buf kept, rx_overrun<=1.
  - rx_valid in the same cycle as a pop write: pop first, then load; rx_full stays 1 with the new byte; no overrun.
- Interrupt:
  - irq_pending set on an accepted RX load when rx_irq_en=1, or on a TX write when tx_irq_en=1.
  - Cleared on the rising edge of intack (intack && !intack_q) or by STATUS write bit3.
  - A set event in the same cycle as a clear wins (stays set).
  - inter = irq_pending, driven from a register.
- Reset values (async, resetn=0): rx_buf=0, rx_full=0, rx_overrun=0, irq_pending=0, CTRL=0, tx_data=0, tx_valid=0, bus_ack=0, intack_q=0, inter=0. Reset asserted mid-access aborts the access; nothing is printed.

Decomposition:
- Shared package holds register offset constants (UART_DATA=0x0, UART_STATUS=0x4, UART_CTRL=0x8) and STATUS/CTRL bit indices; the firmware header mirrors these.
- Single module, no sub-modules.

Test Plan:
- Reset: hold resetn=0 → inter=0, bus_data at 0x4 = 0x2, CTRL reads 0.
- TX: write 0x41 to offset 0x0 with bytesel=0001 for one cycle → tx_valid=1 for exactly one cycle, tx_data=0x41, 'A' printed once. Repeat with bytesel=0010 → no TX.
- RX and pop: pulse rx_valid with rx_data=0x5A → STATUS=0x3, DATA reads 0x5A (twice, unchanged). Write 0x1 to STATUS → STATUS=0x2.
- Overrun and simultaneity: load 0x11, then inject 0x22 → DATA=0x11, STATUS bit2=1. Pop and inject 0x33 in the same cycle → DATA=0x33, rx_full=1, no new overrun.
- IRQ: CTRL=0x1, inject byte → inter=1 next cycle. Raise intack → inter=0 the following cycle. Hold intack high with a new RX → inter re-asserts and stays set until the next intack rising edge.
- Async reset mid-RX: inject byte, assert resetn=0 between clock edges → rx_full, inter, and CTRL clear immediately.
